// File: rtl/light_show_sequencer.sv
// Panel front end for the light-show PWM engine: conditions raw switches, keeps the
// shadow {color, pattern, speed} configuration and offers it atomically over valid/ready.
module light_show_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DWELL_W         = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         color_switch,
    input  logic               speed_switch,
    input  logic               pattern_switch,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [2:0]         cfg_color,
    output logic [1:0]         cfg_pattern,
    output logic [1:0]         cfg_speed,
    output logic               cfg_valid,
    input  logic               cfg_ready
);

    localparam int unsigned N_IN    = 5;
    localparam int unsigned SPD_BIT = 3;
    localparam int unsigned PAT_BIT = 4;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [2:0] color;
        logic [1:0] pattern;
        logic [1:0] speed;
    } cfg_t;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    // Two-flop synchronizers; bit order {pattern, speed, color[2:0]}
    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {pattern_switch, speed_switch, color_switch};
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
    logic [N_IN-1:0] deb;
    logic [DB_W-1:0] db_cnt [N_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Button edge detection and dwell-counter qualifiers
    logic               speed_q;
    logic               pattern_q;
    logic               speed_rise;
    logic               pattern_rise;
    logic               dwell_on;
    logic               dwell_hit;
    logic               dwell_over;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_last;

    always_comb begin
        speed_rise   = deb[SPD_BIT] & ~speed_q;
        pattern_rise = deb[PAT_BIT] & ~pattern_q;
        dwell_on     = auto_en && (dwell_cycles != '0);
        dwell_last   = dwell_cycles - DWELL_W'(1);
        dwell_hit    = dwell_on && (dwell_cnt == dwell_last);
        dwell_over   = dwell_cnt > dwell_last;
    end

    // Shadow configuration; a button edge coinciding with expiry advances once
    cfg_t sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q   <= 1'b0;
            pattern_q <= 1'b0;
            sh        <= '0;
            dwell_cnt <= '0;
        end else begin
            speed_q  <= deb[SPD_BIT];
            pattern_q <= deb[PAT_BIT];
            sh.color <= deb[2:0];
            if (speed_rise) begin
                sh.speed <= sh.speed + 2'd1;
            end
            if (pattern_rise || dwell_hit) begin
                sh.pattern <= sh.pattern + 2'd1;
            end
            if (!dwell_on || pattern_rise || dwell_hit || dwell_over) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

    // Offer FSM: state and offer registers
    state_t state;
    state_t state_d;
    cfg_t   last_acc;
    cfg_t   last_d;
    cfg_t   cfg_q;
    cfg_t   cfg_d;
    logic   init;
    logic   init_d;
    logic   valid_q;
    logic   valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_acc <= '0;
            cfg_q    <= '0;
            init     <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_d;
            last_acc <= last_d;
            cfg_q    <= cfg_d;
            init     <= init_d;
            valid_q  <= valid_d;
        end
    end

    // Offer FSM: next state; outputs stay frozen while an offer is pending
    always_comb begin
        state_d = state;
        last_d  = last_acc;
        cfg_d   = cfg_q;
        init_d  = init;
        valid_d = valid_q;
        case (state)
            IDLE: begin
                if (init || (sh != last_acc)) begin
                    state_d = OFFER;
                    cfg_d   = sh;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                if (cfg_ready) begin
                    state_d = IDLE;
                    last_d  = cfg_q;
                    init_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign cfg_color   = cfg_q.color;
    assign cfg_pattern = cfg_q.pattern;
    assign cfg_speed   = cfg_q.speed;
    assign cfg_valid   = valid_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
// Directed-sequence bench with randomized timing; expected offers come from a
// transaction-level model of the panel (press counts mod 4, switch value, dwell period).
`timescale 1ns/1ps
module tb_light_show_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = DEB + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    color_switch;
    logic          speed_switch;
    logic          pattern_switch;
    logic          auto_en;
    logic [DW-1:0] dwell_cycles;
    logic [2:0]    cfg_color;
    logic [1:0]    cfg_pattern;
    logic [1:0]    cfg_speed;
    logic          cfg_valid;
    logic          cfg_ready;

    int n_cmp = 0;
    int n_err = 0;
    int exp_color = 0;
    int exp_pattern = 0;
    int exp_speed = 0;

    always #5 clk = ~clk;

    light_show_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .DWELL_W        (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .color_switch  (color_switch),
        .speed_switch  (speed_switch),
        .pattern_switch(pattern_switch),
        .auto_en       (auto_en),
        .dwell_cycles  (dwell_cycles),
        .cfg_color     (cfg_color),
        .cfg_pattern   (cfg_pattern),
        .cfg_speed     (cfg_speed),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_offer(input string tag);
        chk({tag, "_valid"},   32'(cfg_valid),   32'(1));
        chk({tag, "_color"},   32'(cfg_color),   exp_color);
        chk({tag, "_pattern"}, 32'(cfg_pattern), exp_pattern);
        chk({tag, "_speed"},   32'(cfg_speed),   exp_speed);
    endtask

    // Steps until cfg_valid is seen; n is the number of edges waited
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (cfg_valid !== 1'b1 && n < budget);
    endtask

    task automatic hold_frozen(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk_offer(tag);
        end
    endtask

    task automatic ack(input string tag);
        cfg_ready = 1'b1;
        step(1);
        cfg_ready = 1'b0;
        chk(tag, 32'(cfg_valid), 32'(0));
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (cfg_valid === 1'b1) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        rst            = 1'b1;
        color_switch   = 3'b000;
        speed_switch   = 1'b0;
        pattern_switch = 1'b0;
        auto_en        = 1'b0;
        dwell_cycles   = '0;
        cfg_ready      = 1'b0;

        // Reset state and init offer
        step(3);
        chk("rst_valid", 32'(cfg_valid), 32'(0));
        chk("rst_cfg", 32'({cfg_color, cfg_pattern, cfg_speed}), 32'(0));
        rst = 1'b0;
        chk("first_idle", 32'(cfg_valid), 32'(0));
        step(1);
        chk_offer("init");
        hold_frozen("init_hold", int'($urandom_range(2, 6)));
        ack("init_ack");
        quiet("init_quiet", 12);

        // Glitches no longer than DEB-1 cycles never reach the shadow
        seen = 0;
        repeat ($urandom_range(4, 8)) begin
            color_switch = 3'b101;
            repeat ($urandom_range(1, DEB - 1)) begin
                step(1);
                if (cfg_valid === 1'b1) seen++;
            end
            color_switch = 3'b000;
            repeat ($urandom_range(1, 3)) begin
                step(1);
                if (cfg_valid === 1'b1) seen++;
            end
        end
        chk("glitch_offers", seen, 0);
        quiet("glitch_quiet", 12);

        // Stable color reaches cfg_valid DEB+4 cycles after the input
        color_switch = 3'b101;
        exp_color    = 5;
        wait_valid(40, n);
        chk("color_latency", n, LAT);
        chk_offer("color");
        ack("color_ack");
        quiet("color_quiet", 10);

        // Speed presses wrap 3 -> 0
        for (int k = 1; k <= 5; k++) begin
            speed_switch = 1'b1;
            exp_speed    = (exp_speed + 1) % 4;
            wait_valid(40, n);
            chk("speed_latency", n, LAT);
            chk_offer("speed");
            hold_frozen("speed_hold", int'($urandom_range(0, 4)));
            ack("speed_ack");
            speed_switch = 1'b0;
            quiet("speed_release", int'($urandom_range(10, 14)));
        end

        // Coalescing: two presses during a held offer collapse into one newer offer
        pattern_switch = 1'b1;
        exp_pattern    = 1;
        wait_valid(40, n);
        chk("pat_latency", n, LAT);
        chk_offer("pat1");
        pattern_switch = 1'b0;
        hold_frozen("pat1_frozen", int'($urandom_range(8, 11)));
        repeat (2) begin
            pattern_switch = 1'b1;
            hold_frozen("pat1_frozen", int'($urandom_range(8, 11)));
            pattern_switch = 1'b0;
            hold_frozen("pat1_frozen", int'($urandom_range(8, 11)));
        end
        ack("pat1_ack");
        exp_pattern = (1 + 2) % 4;
        wait_valid(10, n);
        chk("pat_reoffer_gap", n, 1);
        chk_offer("pat3");
        ack("pat3_ack");
        quiet("pat_quiet", 10);

        // Auto-advance every dwell_cycles with ready tied high
        cfg_ready    = 1'b1;
        auto_en      = 1'b1;
        dwell_cycles = DW'(10);
        for (int k = 0; k < 5; k++) begin
            wait_valid(40, n);
            chk("auto_gap", n, (k == 0) ? 11 : 10);
            exp_pattern = (exp_pattern + 1) % 4;
            chk_offer("auto");
        end

        // Button press landing on the expiry cycle: single step, period restarts
        step(2);
        pattern_switch = 1'b1;
        wait_valid(40, n);
        chk("coincide_gap", n, 8);
        exp_pattern = (exp_pattern + 1) % 4;
        chk_offer("coincide");
        pattern_switch = 1'b0;
        wait_valid(40, n);
        chk("coincide_next_gap", n, 10);
        exp_pattern = (exp_pattern + 1) % 4;
        chk_offer("coincide_next");

        // Lowering dwell below the count clears without advancing
        step(4);
        dwell_cycles = DW'(3);
        wait_valid(40, n);
        chk("dwell_lower_gap", n, 5);
        exp_pattern = (exp_pattern + 1) % 4;
        chk_offer("dwell_lower");
        wait_valid(40, n);
        chk("dwell3_gap", n, 3);
        exp_pattern = (exp_pattern + 1) % 4;
        chk_offer("dwell3");

        auto_en = 1'b0;
        step(2);
        cfg_ready = 1'b0;
        quiet("auto_off", 30);

        // Reset mid-offer abandons it and the init offer repeats
        speed_switch = 1'b1;
        exp_speed    = (exp_speed + 1) % 4;
        wait_valid(40, n);
        chk("pre_reset_latency", n, LAT);
        chk_offer("pre_reset");
        speed_switch = 1'b0;
        color_switch = 3'b000;
        rst          = 1'b1;
        step(1);
        chk("midrst_valid", 32'(cfg_valid), 32'(0));
        chk("midrst_cfg", 32'({cfg_color, cfg_pattern, cfg_speed}), 32'(0));
        step(2);
        rst = 1'b0;
        chk("rerelease_idle", 32'(cfg_valid), 32'(0));
        exp_color   = 0;
        exp_pattern = 0;
        exp_speed   = 0;
        step(1);
        chk_offer("reinit");
        hold_frozen("reinit_hold", 3);
        ack("reinit_ack");
        quiet("reinit_quiet", 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
